sd_cmd_phy: RTL and testbench

Command-line physical layer for the SD host. It sits between the command engine and the card's CMD pin. It serializes a 48-bit command frame (index, argument, CRC7) and waits for the card's response start bit with a timeout. It then deserializes a 48-bit or 136-bit response, checks CRC7, end bit and index, and hands the response plus error flags back to the command engine and the response/error-status registers.

---
 rtl/sd_cmd_phy.sv | 188 ++++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_phy.sv
// SD host command-line PHY: drives a 48-bit command frame onto CMD, then
// captures the 48- or 136-bit card response and checks CRC7, end bit and index.
module sd_cmd_phy #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         sd_clk_en,
   input  logic         cmd_pin_in,
   output logic         cmd_pin_out,
   output logic         cmd_oe,
   input  logic         start,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_argument,
   input  logic [1:0]   resp_type,
   output logic         busy,
   output logic         done,
   output logic [127:0] response,
   output logic         timeout_err,
   output logic         crc_err,
   output logic         end_bit_err,
   output logic         index_err
);
   // state | meaning
   // IDLE  | line released, waiting for start
   // SEND  | driving the command frame, MSB first, one bit per strobe
   // WAIT  | line released, looking for the response start bit
   // RECV  | shifting in the response, one bit per strobe
   // DONE  | one-cycle completion pulse
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t              state_q, state_d;
   logic [47:0]         frame_q, frame_d;
   logic [7:0]          bit_cnt_q, bit_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [126:0]        shift_q, shift_d;
   logic [5:0]          index_q, index_d;
   logic [1:0]          type_q, type_d;
   logic [127:0]        response_q, response_d;
   logic                timeout_q, timeout_d;
   logic                crc_err_q, crc_err_d;
   logic                end_bit_q, end_bit_d;
   logic                index_err_q, index_err_d;

   logic [39:0]         tx_body;
   logic [6:0]          tx_crc;
   logic [127:0]        rx_shift;
   logic [6:0]          rx_crc;
   logic                is_r2;

   // With a zero seed, leading zero bits leave the CRC untouched, so one
   // 120-bit engine serves both the 40-bit and the 120-bit coverage.
   function automatic logic [6:0] crc7(input logic [119:0] data);
      logic [6:0] crc;
      logic       fb;
      crc = '0;
      for (int i = 119; i >= 0; i--) begin
         fb  = data[i] ^ crc[6];
         crc = {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
      end
      return crc;
   endfunction

   assign tx_body  = {2'b01, cmd_index, cmd_argument};
   assign tx_crc   = crc7({80'b0, tx_body});
   assign is_r2    = (type_q == 2'b01);
   // Only the last 128 received bits matter; the R2 header byte falls off the top.
   assign rx_shift = {shift_q, cmd_pin_in};
   assign rx_crc   = is_r2 ? crc7(rx_shift[127:8]) : crc7({80'b0, rx_shift[47:8]});

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      bit_cnt_d   = bit_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      shift_d     = shift_q;
      index_d     = index_q;
      type_d      = type_q;
      response_d  = response_q;
      timeout_d   = timeout_q;
      crc_err_d   = crc_err_q;
      end_bit_d   = end_bit_q;
      index_err_d = index_err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               index_d     = cmd_index;
               type_d      = resp_type;
               frame_d     = {tx_body, tx_crc, 1'b1};
               bit_cnt_d   = 8'd47;
               timeout_d   = 1'b0;
               crc_err_d   = 1'b0;
               end_bit_d   = 1'b0;
               index_err_d = 1'b0;
               state_d     = S_SEND;
            end
         end
         S_SEND: begin
            if (sd_clk_en) begin
               if (bit_cnt_q == 8'd0) begin
                  wait_cnt_d = WAIT_W'(TIMEOUT_CYCLES);
                  state_d    = (type_q == 2'b00) ? S_DONE : S_WAIT;
               end else begin
                  frame_d   = {frame_q[46:0], 1'b1};
                  bit_cnt_d = bit_cnt_q - 8'd1;
               end
            end
         end
         S_WAIT: begin
            if (sd_clk_en) begin
               if (wait_cnt_q == WAIT_W'(1)) begin
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end else if (!cmd_pin_in) begin
                  shift_d   = '0;
                  bit_cnt_d = is_r2 ? 8'd135 : 8'd47;
                  state_d   = S_RECV;
               end else begin
                  wait_cnt_d = wait_cnt_q - WAIT_W'(1);
               end
            end
         end
         S_RECV: begin
            if (sd_clk_en) begin
               shift_d = rx_shift[126:0];
               if (bit_cnt_q == 8'd1) begin
                  end_bit_d = ~cmd_pin_in;
                  if (is_r2) begin
                     response_d = {8'h00, rx_shift[127:8]};
                     crc_err_d  = (rx_crc != rx_shift[7:1]);
                  end else begin
                     response_d  = {96'b0, rx_shift[39:8]};
                     crc_err_d   = (rx_crc != rx_shift[7:1]);
                     index_err_d = (rx_shift[45:40] != index_q);
                  end
                  state_d = S_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q - 8'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         frame_q     <= '0;
         bit_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         shift_q     <= '0;
         index_q     <= '0;
         type_q      <= '0;
         response_q  <= '0;
         timeout_q   <= 1'b0;
         crc_err_q   <= 1'b0;
         end_bit_q   <= 1'b0;
         index_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         bit_cnt_q   <= bit_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         shift_q     <= shift_d;
         index_q     <= index_d;
         type_q      <= type_d;
         response_q  <= response_d;
         timeout_q   <= timeout_d;
         crc_err_q   <= crc_err_d;
         end_bit_q   <= end_bit_d;
         index_err_q <= index_err_d;
      end
   end

   assign cmd_oe      = (state_q == S_SEND);
   assign cmd_pin_out = cmd_oe ? frame_q[47] : 1'b1;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign response    = response_q;
   assign timeout_err = timeout_q;
   assign crc_err     = crc_err_q;
   assign end_bit_err = end_bit_q;
   assign index_err   = index_err_q;
endmodule

// File: tb/tb_sd_cmd_phy.sv
// Bench for sd_cmd_phy: command vectors with an emulated card, expected results
// queued at start and compared when done appears, plus reset/abort sequences.
module tb_sd_cmd_phy;
   localparam int TIMEOUT = 64;

   logic         clock = 1'b0;
   logic         reset, sd_clk_en, cmd_pin_in, cmd_pin_out, cmd_oe, start, busy, done;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_argument;
   logic [1:0]   resp_type;
   logic [127:0] response;
   logic         timeout_err, crc_err, end_bit_err, index_err;

   int checks = 0;
   int errors = 0;

   sd_cmd_phy #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .sd_clk_en(sd_clk_en),
      .cmd_pin_in(cmd_pin_in), .cmd_pin_out(cmd_pin_out), .cmd_oe(cmd_oe),
      .start(start), .cmd_index(cmd_index), .cmd_argument(cmd_argument),
      .resp_type(resp_type), .busy(busy), .done(done), .response(response),
      .timeout_err(timeout_err), .crc_err(crc_err), .end_bit_err(end_bit_err),
      .index_err(index_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      string          name;
      logic [5:0]     idx;
      logic [31:0]    arg;
      logic [1:0]     rtype;
      int             idle_bits;
      int             card_len;
      logic [135:0]   card_frame;
      bit             on_strobe;
      bit             poke;
      logic [47:0]    exp_tx;
      logic [3:0]     exp_err;   // {timeout, crc, end_bit, index}
      logic [127:0]   exp_resp;
      int             exp_wait;  // strobes after SEND until done; -1 = unchecked
   } vec_t;

   vec_t vecs[13];
   vec_t exp_q[$];

   function automatic logic [6:0] tb_crc7(input logic [119:0] d, input int n);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = n - 1; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] tx48(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] b;
      b = {2'b01, idx, arg};
      return {b, tb_crc7({80'b0, b}, 40), 1'b1};
   endfunction

   function automatic logic [135:0] f48(input logic [7:0] hdr, input logic [31:0] arg,
                                        input logic eb);
      return {88'b0, hdr, arg, tb_crc7({80'b0, hdr, arg}, 40), eb};
   endfunction

   function automatic logic [135:0] r2(input logic [119:0] p, input logic [6:0] crc_flip);
      return {8'h3F, p, tb_crc7(p, 120) ^ crc_flip, 1'b1};
   endfunction

   function automatic vec_t mk(input string nm, input logic [5:0] idx, input logic [31:0] arg,
                               input logic [1:0] rt, input int idle, input int len,
                               input logic [135:0] cf, input logic [3:0] err,
                               input logic [127:0] er, input int ew);
      vec_t v;
      v.name = nm;   v.idx = idx;    v.arg = arg;     v.rtype = rt;
      v.idle_bits = idle;  v.card_len = len;  v.card_frame = cf;
      v.on_strobe = 1'b0;  v.poke = 1'b0;
      v.exp_tx = tx48(idx, arg);
      v.exp_err = err;  v.exp_resp = er;  v.exp_wait = ew;
      return v;
   endfunction

   task automatic check(input string nm, input logic [135:0] act, input logic [135:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [47:0] tx;
      int          txn, waitn, cpos, j;
      bit          seen, stb;
      vec_t        e;
      tx = '0; txn = 0; waitn = 0; cpos = 0; seen = 1'b0;
      exp_q.push_back(v);
      @(negedge clock);
      cmd_index = v.idx; cmd_argument = v.arg; resp_type = v.rtype;
      start = 1'b1; sd_clk_en = v.on_strobe;
      @(negedge clock);
      start = 1'b0; sd_clk_en = 1'b0;
      cmd_index = ~v.idx; cmd_argument = ~v.arg; resp_type = ~v.rtype;
      check({v.name, ".busy_after_start"}, 136'(busy), 136'(1));
      for (int cyc = 1; cyc <= 4000; cyc++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         stb = (cyc % 4 == 0);
         cmd_pin_in = 1'b1;
         if (v.poke && cyc == 40) begin
            start = 1'b1; cmd_index = 6'h3F; cmd_argument = '1; resp_type = 2'b01;
         end else begin
            start = 1'b0;
         end
         if (stb) begin
            if (cmd_oe) begin
               tx = {tx[46:0], cmd_pin_out};
               txn++;
            end else if (txn == 48) begin
               j = cpos - v.idle_bits;
               if (cpos >= v.idle_bits && j < v.card_len)
                  cmd_pin_in = v.card_frame[v.card_len - 1 - j];
               cpos++;
               waitn++;
            end
         end
         sd_clk_en = stb;
         @(negedge clock);
      end
      sd_clk_en = 1'b0; start = 1'b0; cmd_pin_in = 1'b1;
      e = exp_q.pop_front();
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s.done_wait: no done within cycle budget, expected done", e.name);
      end else begin
         check({e.name, ".tx_bits"}, 136'(txn), 136'(48));
         check({e.name, ".tx_frame"}, 136'(tx), 136'(e.exp_tx));
         check({e.name, ".err_flags"},
               136'({timeout_err, crc_err, end_bit_err, index_err}), 136'(e.exp_err));
         check({e.name, ".response"}, 136'(response), 136'(e.exp_resp));
         if (e.exp_wait >= 0)
            check({e.name, ".wait_strobes"}, 136'(waitn), 136'(e.exp_wait));
         @(negedge clock);
         check({e.name, ".done_one_cycle"}, 136'({done, busy, cmd_oe, cmd_pin_out}),
               136'(4'b0001));
         check({e.name, ".flags_hold"},
               136'({timeout_err, crc_err, end_bit_err, index_err}), 136'(e.exp_err));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected summary first");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [119:0] pay;
      bit           done_seen;
      pay = 120'h0353_4453_4430_3880_1234_5678_9ABC_DE;

      vecs[0]  = mk("cmd0",      6'd0, 32'h0,        2'b00, 0,    0,   '0,
                    4'b0000, 128'h0, -1);
      vecs[1]  = mk("cmd8_ok",   6'd8, 32'h000001AA, 2'b10, 5,    48,  136'h08000001AA13,
                    4'b0000, 128'h1AA, -1);
      vecs[2]  = mk("cmd8_crc",  6'd8, 32'h000001AA, 2'b10, 5,    48,  136'h08000001AA15,
                    4'b0100, 128'h1AA, -1);
      vecs[3]  = mk("cmd8_idx",  6'd8, 32'h000001AA, 2'b10, 4,    48,  f48(8'h09, 32'h12345678, 1'b1),
                    4'b0001, 128'h12345678, -1);
      vecs[4]  = mk("cmd8_end",  6'd8, 32'h000001AA, 2'b10, 1,    48,  f48(8'h08, 32'hCAFEF00D, 1'b0),
                    4'b0010, 128'hCAFEF00D, -1);
      vecs[5]  = mk("timeout",   6'd8, 32'h000001AA, 2'b10, 1000, 48,  '0,
                    4'b1000, 128'hCAFEF00D, TIMEOUT);
      vecs[6]  = mk("start_at_limit", 6'd8, 32'h0, 2'b10, TIMEOUT - 1, 48,
                    f48(8'h08, 32'h55AA55AA, 1'b1), 4'b1000, 128'hCAFEF00D, TIMEOUT);
      vecs[7]  = mk("start_before_limit", 6'd8, 32'h0, 2'b10, TIMEOUT - 2, 48,
                    f48(8'h08, 32'h55AA55AA, 1'b1), 4'b0000, 128'h55AA55AA, -1);
      vecs[8]  = mk("r2_ok",     6'd2, 32'h0,        2'b01, 3,    136, r2(pay, 7'h00),
                    4'b0000, {8'h00, pay}, -1);
      vecs[9]  = mk("r2_crc",    6'd2, 32'h0,        2'b01, 7,    136, r2(pay, 7'h01),
                    4'b0100, {8'h00, pay}, -1);
      vecs[10] = mk("r1b",       6'd7, 32'h00000ABC, 2'b11, 2,    48,  f48(8'h07, 32'h00000ABC, 1'b1),
                    4'b0000, 128'hABC, -1);
      vecs[11] = mk("start_on_strobe", 6'h11, 32'hDEADBEEF, 2'b00, 0, 0, '0,
                    4'b0000, 128'hABC, -1);
      vecs[12] = mk("start_while_busy", 6'h2A, 32'h0F0F0F0F, 2'b00, 0, 0, '0,
                    4'b0000, 128'hABC, -1);
      vecs[0].exp_tx = 48'h400000000095;
      vecs[1].exp_tx = 48'h48000001AA87;
      vecs[11].on_strobe = 1'b1;
      vecs[12].poke = 1'b1;

      reset = 1'b1; sd_clk_en = 1'b0; start = 1'b0; cmd_pin_in = 1'b1;
      cmd_index = '0; cmd_argument = '0; resp_type = '0;
      repeat (3) @(negedge clock);
      check("reset.pin_out", 136'(cmd_pin_out), 136'(1));
      check("reset.ctrl", 136'({cmd_oe, busy, done}), 136'(0));
      check("reset.flags", 136'({timeout_err, crc_err, end_bit_err, index_err}), 136'(0));
      check("reset.response", 136'(response), 136'(0));
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      @(negedge clock);
      cmd_index = 6'h05; cmd_argument = 32'h1; resp_type = 2'b10; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         sd_clk_en = (c % 4 == 0);
         @(negedge clock);
      end
      sd_clk_en = 1'b0;
      check("abort.oe_before_reset", 136'(cmd_oe), 136'(1));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort.ctrl", 136'({cmd_oe, busy, done}), 136'(0));
      check("abort.pin_out", 136'(cmd_pin_out), 136'(1));
      check("abort.response", 136'(response), 136'(0));
      done_seen = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (done || busy) done_seen = 1'b1;
         sd_clk_en = (c % 4 == 0);
         @(negedge clock);
      end
      sd_clk_en = 1'b0;
      check("abort.no_done", 136'(done_seen), 136'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
